// File: rtl/panel_pkg.sv
// Shared types and elaboration helpers for the LED-panel PWM scan sequencer.
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    SHOW  = 2'd3
  } state_e;

  function automatic int pwm_range(input int width);
    return int'((32'd1 << width) - 32'd1);
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < 32'(n)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/pwm_level_seq.sv
// PWM threshold / row-address sequencer, advanced once per sub-frame by step.
module pwm_level_seq
  import panel_pkg::*;
#(
  parameter int PWM_WIDTH = 12,
  parameter int LVL_INC   = 1,
  parameter int ROW_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 step,
  output logic [PWM_WIDTH-1:0] pwmlvl,
  output logic [ROW_BITS-1:0]  row,
  output logic                 frame_done
);

  localparam int RANGE = pwm_range(PWM_WIDTH);
  localparam logic [PWM_WIDTH:0] INC_W  = (PWM_WIDTH+1)'(LVL_INC);
  // Largest usable level: RANGE itself would compare true for no pixel.
  localparam logic [PWM_WIDTH:0] LAST_W = (PWM_WIDTH+1)'(RANGE - 1);

  logic [PWM_WIDTH-1:0] pwmlvl_r;
  logic [ROW_BITS-1:0]  row_r;
  logic                 frame_done_r;
  logic [PWM_WIDTH:0]   nxt_s;
  logic                 wrap_s;

  assign nxt_s  = {1'b0, pwmlvl_r} + INC_W;
  assign wrap_s = (nxt_s > LAST_W);

  // Level/row registers; frame_done pulses when the row counter wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwmlvl_r     <= '0;
      row_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (step) begin
        if (wrap_s) begin
          pwmlvl_r     <= '0;
          row_r        <= row_r + ROW_BITS'(1);
          frame_done_r <= &row_r;
        end else begin
          pwmlvl_r <= nxt_s[PWM_WIDTH-1:0];
        end
      end
    end
  end

  assign pwmlvl     = pwmlvl_r;
  assign row        = row_r;
  assign frame_done = frame_done_r;

endmodule

// File: rtl/pwm_scan_ctrl.sv
// Sub-frame sequencer: shift COLS pixels, latch, then show for SHOW_CYCLES.
module pwm_scan_ctrl
  import panel_pkg::*;
#(
  parameter int PWM_WIDTH   = 12,
  parameter int LVL_INC     = 1,
  parameter int COLS        = 32,
  parameter int ROW_BITS    = 4,
  parameter int SHOW_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  output logic [PWM_WIDTH-1:0]           pwmlvl,
  output logic [clog2_min1(COLS)-1:0]    col,
  output logic [ROW_BITS-1:0]            row,
  output logic                           sclk,
  output logic                           latch,
  output logic                           oe_n,
  output logic                           frame_done
);

  localparam int COL_W  = clog2_min1(COLS);
  localparam int SHOW_W = clog2_min1(SHOW_CYCLES);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);

  state_e            state_r, state_nxt_s;
  logic              phase_r, phase_nxt_s;
  logic [COL_W-1:0]  col_r, col_nxt_s;
  logic [SHOW_W-1:0] show_cnt_r, show_nxt_s;
  logic              step_s;
  logic              sclk_r, latch_r, oe_n_r;
  logic              sclk_nxt_s, latch_nxt_s, oe_n_nxt_s;

  // State, shift phase, column and show counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      phase_r    <= 1'b0;
      col_r      <= '0;
      show_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      phase_r    <= phase_nxt_s;
      col_r      <= col_nxt_s;
      show_cnt_r <= show_nxt_s;
    end
  end

  // Next-state logic; enable is only looked at in IDLE and the last SHOW cycle.
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = 1'b0;
    col_nxt_s   = col_r;
    show_nxt_s  = '0;
    step_s      = 1'b0;
    case (state_r)
      IDLE: begin
        col_nxt_s = '0;
        if (enable) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (!phase_r) begin
          phase_nxt_s = 1'b1;
        end else if (col_r == COL_LAST) begin
          col_nxt_s   = '0;
          state_nxt_s = LATCH;
        end else begin
          col_nxt_s = col_r + COL_W'(1);
        end
      end
      LATCH: begin
        state_nxt_s = SHOW;
      end
      SHOW: begin
        if (show_cnt_r == SHOW_LAST) begin
          step_s = 1'b1;
          if (enable) begin
            state_nxt_s = SHIFT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          show_nxt_s = show_cnt_r + SHOW_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Panel strobes decoded from the upcoming state so they can be registered.
  always_comb begin
    sclk_nxt_s  = (state_nxt_s == SHIFT) && phase_nxt_s;
    latch_nxt_s = (state_nxt_s == LATCH);
    oe_n_nxt_s  = (state_nxt_s != SHOW);
  end

  // Registered panel strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_r  <= 1'b0;
      latch_r <= 1'b0;
      oe_n_r  <= 1'b1;
    end else begin
      sclk_r  <= sclk_nxt_s;
      latch_r <= latch_nxt_s;
      oe_n_r  <= oe_n_nxt_s;
    end
  end

  pwm_level_seq #(
    .PWM_WIDTH (PWM_WIDTH),
    .LVL_INC   (LVL_INC),
    .ROW_BITS  (ROW_BITS)
  ) u_level_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .step       (step_s),
    .pwmlvl     (pwmlvl),
    .row        (row),
    .frame_done (frame_done)
  );

  assign col   = col_r;
  assign sclk  = sclk_r;
  assign latch = latch_r;
  assign oe_n  = oe_n_r;

endmodule

// File: tb/tb_pwm_scan_ctrl.sv
// Self-checking bench: first sub-frame vector table, frame/level sequencing,
// enable drop, random enable against a sub-frame-position model, async reset.
module tb_pwm_scan_ctrl;

  localparam int PW     = 3;
  localparam int COLS   = 4;
  localparam int RB     = 1;
  localparam int SC     = 2;
  localparam int PERIOD = 2 * COLS + 1 + SC;
  localparam int RANGE  = 7;
  localparam int ROWS   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;

  logic [PW-1:0] a_pwmlvl, b_pwmlvl;
  logic [1:0]    a_col, b_col;
  logic [RB-1:0] a_row, b_row;
  logic a_sclk, a_latch, a_oe_n, a_fd;
  logic b_sclk, b_latch, b_oe_n, b_fd;

  pwm_scan_ctrl #(.PWM_WIDTH(PW), .LVL_INC(1), .COLS(COLS), .ROW_BITS(RB), .SHOW_CYCLES(SC)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwmlvl(a_pwmlvl), .col(a_col), .row(a_row),
    .sclk(a_sclk), .latch(a_latch), .oe_n(a_oe_n), .frame_done(a_fd));

  pwm_scan_ctrl #(.PWM_WIDTH(PW), .LVL_INC(3), .COLS(COLS), .ROW_BITS(RB), .SHOW_CYCLES(SC)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwmlvl(b_pwmlvl), .col(b_col), .row(b_row),
    .sclk(b_sclk), .latch(b_latch), .oe_n(b_oe_n), .frame_done(b_fd));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the current sub-frame plus level/row.
  typedef struct {
    bit running;
    int pos;
    int lvl;
    int row;
    bit fd;
  } model_t;

  function automatic model_t model_step(model_t m, bit en, int inc);
    model_t n;
    n = m;
    n.fd = 1'b0;
    if (!m.running) begin
      if (en) begin
        n.running = 1'b1;
        n.pos = 0;
      end
    end else if (m.pos == PERIOD - 1) begin
      if (m.lvl + inc <= RANGE - 1) begin
        n.lvl = m.lvl + inc;
      end else begin
        n.lvl = 0;
        n.row = (m.row + 1) % ROWS;
        n.fd  = (m.row == ROWS - 1);
      end
      n.running = en;
      n.pos = 0;
    end else begin
      n.pos = m.pos + 1;
    end
    return n;
  endfunction

  model_t ma, mb;
  bit chk_on = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= model_step(ma, enable, 1);
      mb <= model_step(mb, enable, 3);
    end
  end

  task automatic check_dut(input string t, input model_t m, input logic [PW-1:0] lvl,
                           input logic [RB-1:0] row, input logic [1:0] col, input logic sclk,
                           input logic latch, input logic oe_n, input logic fd);
    bit in_shift;
    in_shift = m.running && (m.pos < 2 * COLS);
    chk({t, ".pwmlvl"}, 32'(lvl), 32'(m.lvl));
    chk({t, ".row"}, 32'(row), 32'(m.row));
    chk({t, ".col"}, 32'(col), in_shift ? 32'(m.pos / 2) : 32'd0);
    chk({t, ".sclk"}, 32'(sclk), 32'(in_shift && (m.pos % 2 == 1)));
    chk({t, ".latch"}, 32'(latch), 32'(m.running && m.pos == 2 * COLS));
    chk({t, ".oe_n"}, 32'(oe_n), 32'(!(m.running && m.pos > 2 * COLS)));
    chk({t, ".frame_done"}, 32'(fd), 32'(m.fd));
    chk({t, ".sclk_latch_excl"}, 32'(sclk & latch), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n && chk_on) begin
      check_dut("a", ma, a_pwmlvl, a_row, a_col, a_sclk, a_latch, a_oe_n, a_fd);
      check_dut("b", mb, b_pwmlvl, b_row, b_col, b_sclk, b_latch, b_oe_n, b_fd);
    end
  end

  typedef struct {
    bit en;
    int col;
    bit sclk;
    bit latch;
    bit oe_n;
  } vec_t;

  vec_t tbl[13];
  int fd_cnt, fd_at, max_lvl, oe_low, nl, nr;
  bit found;

  initial begin
    tbl[0]  = '{1'b0, 0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 2, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 2, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 3, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 0, 1'b0, 1'b0, 1'b1};

    #12;
    chk("reset.oe_n", 32'(a_oe_n), 32'd1);
    chk("reset.sclk", 32'(a_sclk), 32'd0);
    chk("reset.latch", 32'(a_latch), 32'd0);
    chk("reset.pwmlvl", 32'(a_pwmlvl), 32'd0);
    chk("reset.row", 32'(a_row), 32'd0);
    chk("reset.frame_done", 32'(a_fd), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_on = 1'b1;

    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en;
      @(negedge clk);
      chk($sformatf("tbl%0d.col", i), 32'(a_col), 32'(tbl[i].col));
      chk($sformatf("tbl%0d.sclk", i), 32'(a_sclk), 32'(tbl[i].sclk));
      chk($sformatf("tbl%0d.latch", i), 32'(a_latch), 32'(tbl[i].latch));
      chk($sformatf("tbl%0d.oe_n", i), 32'(a_oe_n), 32'(tbl[i].oe_n));
    end

    // Continuous run from the first SHIFT cycle (run cycle 0 = table entry 1).
    fd_cnt = 0;
    fd_at = -1;
    max_lvl = 0;
    for (int rc = 12; rc <= 170; rc++) begin
      @(negedge clk);
      if (a_fd) begin
        fd_cnt++;
        fd_at = rc;
      end
      if (int'(a_pwmlvl) > max_lvl) max_lvl = int'(a_pwmlvl);
      if (rc == 22) chk("inc3.sf2.lvl", 32'(b_pwmlvl), 32'd6);
      if (rc == 33) begin
        chk("inc3.sf3.lvl", 32'(b_pwmlvl), 32'd0);
        chk("inc3.sf3.row", 32'(b_row), 32'd1);
      end
      if (rc == 44) chk("inc3.sf4.lvl", 32'(b_pwmlvl), 32'd3);
    end
    chk("frame_done.count", 32'(fd_cnt), 32'd1);
    chk("frame_done.cycle", 32'(fd_at), 32'd154);
    chk("pwmlvl.max", 32'(max_lvl), 32'd6);

    // Drop enable mid-SHIFT: the sub-frame must finish, then idle.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (ma.running && ma.pos == 3) found = 1'b1;
    end
    chk("drop.found_shift", 32'(found), 32'd1);
    enable = 1'b0;
    nl = (ma.lvl + 1 <= RANGE - 1) ? ma.lvl + 1 : 0;
    nr = (ma.lvl + 1 <= RANGE - 1) ? ma.row : (ma.row + 1) % ROWS;
    oe_low = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!a_oe_n) oe_low++;
    end
    chk("drop.oe_low_cycles", 32'(oe_low), 32'd2);
    chk("drop.idle_oe_n", 32'(a_oe_n), 32'd1);
    chk("drop.idle_pwmlvl", 32'(a_pwmlvl), 32'(nl));
    chk("drop.idle_row", 32'(a_row), 32'(nr));
    enable = 1'b1;
    @(negedge clk);
    chk("resume.col", 32'(a_col), 32'd0);
    chk("resume.oe_n", 32'(a_oe_n), 32'd1);
    chk("resume.pwmlvl", 32'(a_pwmlvl), 32'(nl));

    // Random enable; the model checker compares every cycle.
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      @(negedge clk);
    end
    enable = 1'b1;

    // Asynchronous reset in the middle of SHOW.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (ma.running && ma.pos == 2 * COLS + 1) found = 1'b1;
    end
    chk("areset.found_show", 32'(found), 32'd1);
    chk("areset.pre_oe_n", 32'(a_oe_n), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset.oe_n", 32'(a_oe_n), 32'd1);
    chk("areset.pwmlvl", 32'(a_pwmlvl), 32'd0);
    chk("areset.row", 32'(a_row), 32'd0);
    chk("areset.sclk", 32'(a_sclk), 32'd0);
    chk("areset.latch", 32'(a_latch), 32'd0);
    chk("areset.col", 32'(a_col), 32'd0);
    chk("areset.b_oe_n", 32'(b_oe_n), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
